// File: rtl/dda_chain_oscillator.sv
// Time-multiplexed Euler solver for a chain of spring-coupled, damped masses
// with fixed ends. One shared signed multiplier walks three force terms per
// mass, then one integration per mass per cycle, then streams positions out.
module dda_chain_oscillator #(
  parameter int N_MASS   = 4,
  parameter int W        = 18,
  parameter int FRAC     = 16,
  parameter int DT_SHIFT = 8,
  parameter int DIV_W    = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                clear,
  input  logic                run,
  input  logic                step_req,
  input  logic [DIV_W-1:0]    step_div,
  input  logic signed [W-1:0] kc,
  input  logic signed [W-1:0] k0,
  input  logic signed [W-1:0] g,
  input  logic                init_we,
  input  logic [3:0]          init_idx,
  input  logic signed [W-1:0] init_x,
  input  logic signed [W-1:0] init_v,
  output logic                busy,
  output logic [31:0]         step_count,
  output logic                overflow,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [3:0]          sample_idx,
  output logic [W-1:0]        sample_x
);

  localparam int IW = (N_MASS > 1) ? $clog2(N_MASS) : 1;
  localparam int PW = 2 * W;
  localparam int AW = W + 3;
  localparam logic [IW-1:0] LAST = IW'(N_MASS - 1);
  localparam logic [4:0]    NM5  = 5'(N_MASS);

  typedef enum logic [1:0] {S_IDLE, S_ACCEL, S_UPDATE, S_EMIT} state_t;
  state_t state;

  logic signed [W-1:0] x [N_MASS];
  logic signed [W-1:0] v [N_MASS];
  logic signed [W-1:0] a [N_MASS];

  logic [IW-1:0]       mi;
  logic [1:0]          ph;
  logic signed [AW-1:0] acc;
  logic [DIV_W-1:0]    div_cnt;
  logic                pending;

  logic                tick;
  logic                trigger;
  logic                idx_ok;
  logic [IW-1:0]       mi_inc;
  logic signed [W-1:0] xl, xr, xi, vi, ai;
  logic signed [W+1:0] lap;
  logic signed [W-1:0] lap_sat;
  logic signed [W-1:0] mul_a, mul_b;
  logic                neg;
  logic signed [PW-1:0] prod, term, term_sh;
  logic signed [W-1:0] term_sat;
  logic signed [AW-1:0] acc_base, acc_next;
  logic signed [W-1:0] acc_sat;
  logic                accel_ovf;
  logic signed [PW-1:0] v_sum, x_sum;
  logic signed [W-1:0] v_new, x_new;
  logic                upd_ovf;

  // True when a sign-extended value is representable in W bits.
  function automatic logic fits_w(input logic signed [PW-1:0] val);
    return (val[PW-1:W-1] == '0) || (val[PW-1:W-1] == '1);
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] val);
    if (fits_w(val))  return val[W-1:0];
    else if (val[PW-1]) return {1'b1, {(W-1){1'b0}}};
    else              return {1'b0, {(W-1){1'b1}}};
  endfunction

  assign tick    = run && (div_cnt == step_div);
  assign trigger = (state == S_IDLE) &&
                   ((run && (tick || pending)) || (!run && step_req));
  assign idx_ok  = ({1'b0, init_idx} < NM5);
  assign mi_inc  = mi + IW'(1);

  // Shared datapath: force term for the current (mass, phase) and the Euler update.
  always_comb begin
    xi = x[mi];
    vi = v[mi];
    ai = a[mi];
    xl = (mi == '0)  ? '0 : x[mi - IW'(1)];
    xr = (mi == LAST) ? '0 : x[mi_inc];
    lap     = (W+2)'(xl) + (W+2)'(xr) - ((W+2)'(xi) <<< 1);
    lap_sat = sat_w(PW'(lap));
    mul_a = g;
    mul_b = vi;
    neg   = 1'b1;
    case (ph)
      2'd0:    begin mul_a = kc; mul_b = lap_sat; neg = 1'b0; end
      2'd1:    begin mul_a = k0; mul_b = xi;      neg = 1'b1; end
      default: begin mul_a = g;  mul_b = vi;      neg = 1'b1; end
    endcase
    // Negate the full-width product before the shift so rounding matches -(k*x)>>>FRAC.
    prod     = PW'(mul_a) * PW'(mul_b);
    term     = neg ? -prod : prod;
    term_sh  = term >>> FRAC;
    term_sat = sat_w(term_sh);
    acc_base = (ph == 2'd0) ? '0 : acc;
    acc_next = acc_base + AW'(term_sat);
    acc_sat  = sat_w(PW'(acc_next));
    accel_ovf = !fits_w(term_sh) ||
                ((ph == 2'd0) && !fits_w(PW'(lap))) ||
                ((ph == 2'd2) && !fits_w(PW'(acc_next)));
    v_sum   = PW'(vi) + PW'(ai >>> DT_SHIFT);
    x_sum   = PW'(xi) + PW'(vi >>> DT_SHIFT);
    v_new   = sat_w(v_sum);
    x_new   = sat_w(x_sum);
    upd_ovf = !fits_w(v_sum) || !fits_w(x_sum);
  end

  // Tick divider: counts 0..step_div while running, parked at 0 otherwise.
  always_ff @(posedge CLOCK_50) begin
    if (reset || !run)              div_cnt <= '0;
    else if (div_cnt == step_div)   div_cnt <= '0;
    else                            div_cnt <= div_cnt + DIV_W'(1);
  end

  // Step sequencer: state arrays, accumulation, integration and sample stream.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      step_count   <= '0;
      overflow     <= 1'b0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      sample_x     <= '0;
      mi           <= '0;
      ph           <= '0;
      acc          <= '0;
      pending      <= 1'b0;
      for (int unsigned k = 0; k < N_MASS; k++) begin
        x[k] <= '0;
        v[k] <= '0;
        a[k] <= '0;
      end
    end else begin
      if (trigger)          pending <= 1'b0;
      else if (tick && busy) pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (clear) begin
            for (int unsigned k = 0; k < N_MASS; k++) begin
              x[k] <= '0;
              v[k] <= '0;
            end
            step_count <= '0;
            overflow   <= 1'b0;
          end else if (init_we && idx_ok) begin
            x[init_idx[IW-1:0]] <= init_x;
            v[init_idx[IW-1:0]] <= init_v;
          end
          if (trigger) begin
            state <= S_ACCEL;
            busy  <= 1'b1;
            mi    <= '0;
            ph    <= '0;
          end
        end
        S_ACCEL: begin
          acc <= acc_next;
          if (accel_ovf) overflow <= 1'b1;
          if (ph == 2'd2) begin
            a[mi] <= acc_sat;
            ph    <= '0;
            if (mi == LAST) begin
              mi    <= '0;
              state <= S_UPDATE;
            end else begin
              mi <= mi_inc;
            end
          end else begin
            ph <= ph + 2'd1;
          end
        end
        S_UPDATE: begin
          v[mi] <= v_new;
          x[mi] <= x_new;
          if (upd_ovf) overflow <= 1'b1;
          if (mi == LAST) begin
            // x[0] was already written on the first update cycle.
            mi           <= '0;
            state        <= S_EMIT;
            sample_valid <= 1'b1;
            sample_idx   <= '0;
            sample_x     <= x[0];
          end else begin
            mi <= mi_inc;
          end
        end
        default: begin
          if (sample_valid && sample_ready) begin
            if (mi == LAST) begin
              mi           <= '0;
              sample_valid <= 1'b0;
              busy         <= 1'b0;
              step_count   <= step_count + 32'd1;
              state        <= S_IDLE;
            end else begin
              mi         <= mi_inc;
              sample_idx <= 4'(mi_inc);
              sample_x   <= x[mi_inc];
            end
          end
        end
      endcase
    end
  end

endmodule
